// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and its round-robin picker.
package dmem_arb_pkg;

  localparam int NUM_PORTS  = 2;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Index of a requester; one bit is enough for two ports.
  typedef logic port_t;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input port_t p);
    port_onehot    = '0;
    port_onehot[p] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: the port not granted last wins a tie,
// a lone requester wins regardless of the pointer.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] i_req,
  input  port_t                i_last_gnt,
  output port_t                o_winner,
  output logic                 o_any
);

  always_comb begin
    o_any    = |i_req;
    o_winner = 1'b0;
    if (i_req == 2'b11)
      o_winner = ~i_last_gnt;
    else if (i_req[1])
      o_winner = 1'b1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the 16-bit data memory.
// Optional word-alignment rejection is enabled by defining DMEM_ARB_ALIGN_CHK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [NUM_PORTS-1:0] i_we,
  input  logic [NUM_PORTS-1:0] i_sb,
  input  logic [ADDR_W-1:0]    i_addr0,
  input  logic [ADDR_W-1:0]    i_addr1,
  input  logic [DATA_W-1:0]    i_wdata0,
  input  logic [DATA_W-1:0]    i_wdata1,
  output logic [NUM_PORTS-1:0] o_gnt,
  output logic [NUM_PORTS-1:0] o_rvalid,
  output logic [DATA_W-1:0]    o_rdata,
  output logic                 o_err,
  output logic                 o_mem_we,
  output logic                 o_mem_re,
  output logic                 o_mem_sb,
  output logic [ADDR_W-1:0]    o_mem_addr,
  output logic [DATA_W-1:0]    o_mem_wdata,
  input  logic [DATA_W-1:0]    i_mem_rdata
);

  state_t                 r_state;
  port_t                  r_last_gnt;
  port_t                  r_port;
  logic                   r_we;
  logic                   r_bad;
  logic [NUM_PORTS-1:0]   r_gnt;
  logic [NUM_PORTS-1:0]   r_rvalid;
  logic [DATA_W-1:0]      r_rdata;
  logic                   r_err;
  logic                   r_mem_we;
  logic                   r_mem_re;
  logic                   r_mem_sb;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic [DATA_W-1:0]      r_mem_wdata;

  port_t                  w_winner;
  logic                   w_any;
  logic                   w_we;
  logic                   w_sb;
  logic                   w_bad;
  logic [ADDR_W-1:0]      w_addr;
  logic [DATA_W-1:0]      w_wdata;

  rr_arb2 u_rr_arb2 (
    .i_req      (i_req),
    .i_last_gnt (r_last_gnt),
    .o_winner   (w_winner),
    .o_any      (w_any)
  );

  assign w_we    = w_winner ? i_we[1]  : i_we[0];
  assign w_sb    = w_winner ? i_sb[1]  : i_sb[0];
  assign w_addr  = w_winner ? i_addr1  : i_addr0;
  assign w_wdata = w_winner ? i_wdata1 : i_wdata0;

`ifdef DMEM_ARB_ALIGN_CHK_EN
  assign w_bad = !w_sb && w_addr[0];
`else
  assign w_bad = 1'b0;
`endif

  // Memory strobes are registered so an asynchronous reset kills an in-flight write.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_last_gnt  <= 1'b1;
      r_port      <= 1'b0;
      r_we        <= 1'b0;
      r_bad       <= 1'b0;
      r_gnt       <= '0;
      r_rvalid    <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_sb    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rvalid <= '0;
          r_err    <= 1'b0;
          if (w_any) begin
            r_state     <= ACCESS;
            r_port      <= w_winner;
            r_last_gnt  <= w_winner;
            r_gnt       <= port_onehot(w_winner);
            r_we        <= w_we;
            r_bad       <= w_bad;
            r_mem_we    <= w_we && !w_bad;
            r_mem_re    <= !w_we && !w_bad;
            r_mem_sb    <= w_sb;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
          end
        end
        ACCESS: begin
          r_state  <= IDLE;
          r_gnt    <= '0;
          r_mem_we <= 1'b0;
          r_mem_re <= 1'b0;
          r_rvalid <= port_onehot(r_port);
          r_err    <= r_bad;
          r_rdata  <= (r_we || r_bad) ? '0 : i_mem_rdata;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_rvalid    = r_rvalid;
  assign o_rdata     = r_rdata;
  assign o_err       = r_err;
  assign o_mem_we    = r_mem_we;
  assign o_mem_re    = r_mem_re;
  assign o_mem_sb    = r_mem_sb;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule
